// File: rtl/uart_rx_cfg_pkg.sv
// Shared UART definitions: parity modes, receiver states, legal parameter ranges.
// Used by uart_rx_cfg today and by the transmitter later.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } rx_state_t;

  localparam int CLK_DIV_MIN     = 4;
  localparam int DATA_BITS_MIN   = 5;
  localparam int DATA_BITS_MAX   = 9;
  localparam int PARITY_MAX      = 2;
  localparam int STOP_BITS_MIN   = 1;
  localparam int STOP_BITS_MAX   = 2;
  localparam int SYNC_STAGES_MIN = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // States in which the bit-window counter runs.
  function automatic logic is_counting(input rx_state_t s);
    return s inside {S_START, S_DATA, S_PARITY, S_STOP};
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Received-word handshake: data and error flags qualified by valid, accepted by ready.
// Master drives the word; slave returns ready.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_parity_err;
  logic                 o_frame_err;
  logic                 o_overrun;

  modport master (
    output o_data, o_valid, o_parity_err, o_frame_err, o_overrun,
    input  i_ready
  );

  modport slave (
    input  o_data, o_valid, o_parity_err, o_frame_err, o_overrun,
    output i_ready
  );
endinterface

// File: rtl/uart_rx_cfg_sampler.sv
// RX synchroniser, bit-window counter and 3-sample majority vote; strobe at cnt = MID+1.
// No backpressure: the counter free-runs while i_run is high and is cleared otherwise.
module uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int CLK_DIV     = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rx,
  input  logic i_run,
  output logic o_rx_s,
  output logic o_bit_strobe,
  output logic o_bit_value
);

  localparam int MID   = CLK_DIV / 2;
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_V0   = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] CNT_V1   = CNT_W'(MID);
  localparam logic [CNT_W-1:0] CNT_V2   = CNT_W'(MID + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   vote0_q, vote1_q;

  assign o_rx_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d = '0;
    if (i_run && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q  <= '1;
      cnt_q   <= '0;
      vote0_q <= 1'b1;
      vote1_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
      cnt_q  <= cnt_d;
      if (cnt_q == CNT_V0) vote0_q <= o_rx_s;
      if (cnt_q == CNT_V1) vote1_q <= o_rx_s;
    end
  end

  // Third vote is taken live in the decision cycle itself.
  assign o_bit_strobe = (cnt_q == CNT_V2);
  assign o_bit_value  = maj3(vote0_q, vote1_q, o_rx_s);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver; o_valid rises one cycle after the last stop-bit decision.
// One-entry holding register: a frame finishing while the word is unaccepted is dropped with o_overrun.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_DIV     = 10,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_rx,
  output logic          o_busy,
  uart_rx_cfg_if.master rx_if
);

  if (CLK_DIV < CLK_DIV_MIN) begin : g_bad_clk_div
    $error("uart_rx_cfg: CLK_DIV out of range");
  end
  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
    $error("uart_rx_cfg: DATA_BITS out of range");
  end
  if (PARITY < 0 || PARITY > PARITY_MAX) begin : g_bad_parity
    $error("uart_rx_cfg: PARITY out of range");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
    $error("uart_rx_cfg: STOP_BITS out of range");
  end
  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
    $error("uart_rx_cfg: SYNC_STAGES out of range");
  end

  localparam parity_t PAR_CFG = parity_t'(PARITY);

  rx_state_t            state_q, state_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, data_q;
  logic                 par_err_q, par_err_d, frm_err_q, frm_err_d, frm_final;
  logic                 valid_q, perr_q, ferr_q, ovr_q;
  logic                 load_req, load, cnt_run;
  logic                 rx_s, bit_strobe, bit_value;

  assign cnt_run = is_counting(state_q) && is_counting(state_d);

  uart_bit_sampler #(
    .CLK_DIV    (CLK_DIV),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sampler (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rx        (i_rx),
    .i_run       (cnt_run),
    .o_rx_s      (rx_s),
    .o_bit_strobe(bit_strobe),
    .o_bit_value (bit_value)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shreg_d    = shreg_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    frm_final  = frm_err_q;
    load_req   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d    = S_START;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          par_err_d  = 1'b0;
          frm_err_d  = 1'b0;
        end
      end
      S_START: begin
        if (bit_strobe) state_d = bit_value ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (bit_strobe) begin
          shreg_d = {bit_value, shreg_q[DATA_BITS-1:1]};
          if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
            state_d = (PAR_CFG == PAR_NONE) ? S_STOP : S_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_strobe) begin
          par_err_d = ((^shreg_q) ^ bit_value) != (PAR_CFG == PAR_ODD);
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_strobe) begin
          frm_final = frm_err_q | ~bit_value;
          frm_err_d = frm_final;
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            load_req = 1'b1;
            // A low line after a bad stop is a break: wait for it to clear.
            state_d  = frm_final ? S_WAIT_HIGH : S_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign load = load_req && (!valid_q || rx_if.i_ready);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shreg_q    <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shreg_q    <= shreg_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      ovr_q      <= load_req && !load;
      // A load in the accept cycle keeps valid high.
      valid_q    <= load || (valid_q && !rx_if.i_ready);
      if (load) begin
        data_q <= shreg_q;
        perr_q <= par_err_q;
        ferr_q <= frm_final;
      end
    end
  end

  assign rx_if.o_data       = data_q;
  assign rx_if.o_valid      = valid_q;
  assign rx_if.o_parity_err = perr_q;
  assign rx_if.o_frame_err  = ferr_q;
  assign rx_if.o_overrun    = ovr_q;
  assign o_busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 and a 7E2 instance, scoreboard queues popped on each accepted word.
module tb_uart_rx_cfg;

  localparam int CD = 10;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rx8 = 1'b1;
  logic rx7 = 1'b1;
  logic busy8, busy7;

  uart_rx_cfg_if #(.DATA_BITS(8)) if8 ();
  uart_rx_cfg_if #(.DATA_BITS(7)) if7 ();

  uart_rx_cfg #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx8), .o_busy(busy8), .rx_if(if8.master)
  );
  uart_rx_cfg #(.CLK_DIV(CD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .SYNC_STAGES(2)) dut7 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx7), .o_busy(busy7), .rx_if(if7.master)
  );

  always #5 clk = ~clk;

  exp_t q8[$];
  exp_t q7[$];
  exp_t e8, e7;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int vld8_cyc = 0, vld8_rises = 0, ovr8_cnt = 0, t_fall8 = 0, t_valid8 = -1;
  logic prev_v8 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [8:0] d, input logic p, input logic f);
    exp_t x;
    x.data = d;
    x.perr = p;
    x.ferr = f;
    return x;
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (if8.o_valid) vld8_cyc++;
      if (if8.o_valid && !prev_v8) begin
        vld8_rises++;
        t_valid8 = cyc;
      end
      if (if8.o_overrun) ovr8_cnt++;
      if (if8.o_valid && if8.i_ready) begin
        n_cmp++;
        if (q8.size() == 0) begin
          n_bad++;
          $display("FAIL mon8_unexpected: got data %h, scoreboard empty", if8.o_data);
        end else begin
          e8 = q8.pop_front();
          if ({1'b0, if8.o_data} !== e8.data || if8.o_parity_err !== e8.perr || if8.o_frame_err !== e8.ferr) begin
            n_bad++;
            $display("FAIL mon8_word: got d=%h p=%b f=%b, need d=%h p=%b f=%b",
                     if8.o_data, if8.o_parity_err, if8.o_frame_err, e8.data, e8.perr, e8.ferr);
          end
        end
      end
    end
    prev_v8 = if8.o_valid;
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && if7.o_valid && if7.i_ready) begin
      n_cmp++;
      if (q7.size() == 0) begin
        n_bad++;
        $display("FAIL mon7_unexpected: got data %h, scoreboard empty", if7.o_data);
      end else begin
        e7 = q7.pop_front();
        if ({2'b0, if7.o_data} !== e7.data || if7.o_parity_err !== e7.perr || if7.o_frame_err !== e7.ferr) begin
          n_bad++;
          $display("FAIL mon7_word: got d=%h p=%b f=%b, need d=%h p=%b f=%b",
                   if7.o_data, if7.o_parity_err, if7.o_frame_err, e7.data, e7.perr, e7.ferr);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit which, input logic v);
    if (which) rx7 = v;
    else rx8 = v;
  endtask

  // Frame on rx8 (which=0) or rx7 (which=1); spike_bit >= 0 inverts one cycle at that bit's middle.
  task automatic send_frame(input bit which, input logic [8:0] d, input int nb, input int par,
                            input bit bad_par, input int nstop, input int spike_bit);
    logic p;
    drive(which, 1'b0);
    if (!which) t_fall8 = cyc;
    cycles(CD);
    p = 1'b0;
    for (int i = 0; i < nb; i++) begin
      p ^= d[i];
      drive(which, d[i]);
      if (i == spike_bit) begin
        cycles(6);
        drive(which, ~d[i]);
        cycles(1);
        drive(which, d[i]);
        cycles(CD - 7);
      end else begin
        cycles(CD);
      end
    end
    if (par != 0) begin
      p = ((par == 1) ? ~p : p) ^ bad_par;
      drive(which, p);
      cycles(CD);
    end
    for (int s = 0; s < nstop; s++) begin
      drive(which, 1'b1);
      cycles(CD);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    if8.i_ready = 1'b1;
    if7.i_ready = 1'b1;
    cycles(3);
    n_cmp++;
    if ({if8.o_data, if8.o_valid, if8.o_parity_err, if8.o_frame_err, if8.o_overrun, busy8} !== 14'h0) begin
      n_bad++;
      $display("FAIL reset_dut8: got d=%h v=%b p=%b f=%b o=%b busy=%b, need all zero",
               if8.o_data, if8.o_valid, if8.o_parity_err, if8.o_frame_err, if8.o_overrun, busy8);
    end
    n_cmp++;
    if ({if7.o_data, if7.o_valid, if7.o_parity_err, if7.o_frame_err, if7.o_overrun, busy7} !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_dut7: got d=%h v=%b p=%b f=%b o=%b busy=%b, need all zero",
               if7.o_data, if7.o_valid, if7.o_parity_err, if7.o_frame_err, if7.o_overrun, busy7);
    end
    rst = 1'b0;
    cycles(5);
  endtask

  task automatic test_8n1_basic;
    int r0, c0;
    r0 = vld8_rises;
    c0 = vld8_cyc;
    t_valid8 = -1;
    q8.push_back(mk(9'h0A5, 1'b0, 1'b0));
    send_frame(1'b0, 9'h0A5, 8, 0, 1'b0, 1, -1);
    cycles(5);
    n_cmp++;
    if (t_valid8 - t_fall8 != 100) begin
      n_bad++;
      $display("FAIL latency_8n1: got %0d cycles, need 100", t_valid8 - t_fall8);
    end
    n_cmp++;
    if (vld8_cyc - c0 != 1) begin
      n_bad++;
      $display("FAIL valid_width_8n1: got %0d cycles high, need 1", vld8_cyc - c0);
    end
    n_cmp++;
    if (vld8_rises - r0 != 1 || q8.size() != 0) begin
      n_bad++;
      $display("FAIL word_count_8n1: got %0d rises, %0d pending, need 1 and 0", vld8_rises - r0, q8.size());
    end
  endtask

  task automatic test_parity_7e2;
    q7.push_back(mk(9'h041, 1'b1, 1'b0));
    send_frame(1'b1, 9'h041, 7, 2, 1'b1, 2, -1);
    q7.push_back(mk(9'h007, 1'b0, 1'b0));
    send_frame(1'b1, 9'h007, 7, 2, 1'b0, 2, -1);
    cycles(5);
    n_cmp++;
    if (q7.size() != 0) begin
      n_bad++;
      $display("FAIL parity_7e2_drain: got %0d words pending, need 0", q7.size());
    end
  endtask

  task automatic test_glitch;
    int r0;
    r0 = vld8_rises;
    rx8 = 1'b0;
    cycles(3);
    rx8 = 1'b1;
    cycles(4);
    n_cmp++;
    if (busy8 !== 1'b1) begin
      n_bad++;
      $display("FAIL glitch_start_seen: got busy=%b, need 1", busy8);
    end
    cycles(20);
    n_cmp++;
    if (busy8 !== 1'b0 || vld8_rises != r0) begin
      n_bad++;
      $display("FAIL glitch_rejected: got busy=%b rises=%0d, need busy=0 rises=0", busy8, vld8_rises - r0);
    end
  endtask

  task automatic test_frame_err;
    int r0;
    r0 = vld8_rises;
    q8.push_back(mk(9'h000, 1'b0, 1'b1));
    rx8 = 1'b0;
    cycles(9 * CD + 30);
    n_cmp++;
    if (busy8 !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_wait_high: got busy=%b while line low, need 1", busy8);
    end
    rx8 = 1'b1;
    cycles(10);
    n_cmp++;
    if (busy8 !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_release: got busy=%b after line high, need 0", busy8);
    end
    cycles(20);
    n_cmp++;
    if (vld8_rises - r0 != 1 || q8.size() != 0) begin
      n_bad++;
      $display("FAIL frame_single_word: got %0d rises, %0d pending, need 1 and 0", vld8_rises - r0, q8.size());
    end
  endtask

  task automatic test_overrun;
    int o0;
    o0 = ovr8_cnt;
    if8.i_ready = 1'b0;
    q8.push_back(mk(9'h011, 1'b0, 1'b0));
    send_frame(1'b0, 9'h011, 8, 0, 1'b0, 1, -1);
    send_frame(1'b0, 9'h022, 8, 0, 1'b0, 1, -1);
    cycles(5);
    n_cmp++;
    if (if8.o_valid !== 1'b1 || if8.o_data !== 8'h11) begin
      n_bad++;
      $display("FAIL overrun_hold: got v=%b d=%h, need v=1 d=11", if8.o_valid, if8.o_data);
    end
    n_cmp++;
    if (ovr8_cnt - o0 != 1) begin
      n_bad++;
      $display("FAIL overrun_pulse: got %0d cycles, need 1", ovr8_cnt - o0);
    end
    if8.i_ready = 1'b1;
    cycles(3);
    n_cmp++;
    if (if8.o_valid !== 1'b0 || q8.size() != 0) begin
      n_bad++;
      $display("FAIL overrun_drain: got v=%b pending=%0d, need v=0 pending=0", if8.o_valid, q8.size());
    end
  endtask

  task automatic test_spike;
    q8.push_back(mk(9'h05A, 1'b0, 1'b0));
    send_frame(1'b0, 9'h05A, 8, 0, 1'b0, 1, 0);
    q8.push_back(mk(9'h0F3, 1'b0, 1'b0));
    send_frame(1'b0, 9'h0F3, 8, 0, 1'b0, 1, 4);
    cycles(5);
    n_cmp++;
    if (q8.size() != 0) begin
      n_bad++;
      $display("FAIL spike_drain: got %0d pending, need 0", q8.size());
    end
  endtask

  task automatic test_back_to_back;
    int r0;
    r0 = vld8_rises;
    q8.push_back(mk(9'h03C, 1'b0, 1'b0));
    q8.push_back(mk(9'h0C3, 1'b0, 1'b0));
    q8.push_back(mk(9'h0FF, 1'b0, 1'b0));
    send_frame(1'b0, 9'h03C, 8, 0, 1'b0, 1, -1);
    send_frame(1'b0, 9'h0C3, 8, 0, 1'b0, 1, -1);
    send_frame(1'b0, 9'h0FF, 8, 0, 1'b0, 1, -1);
    cycles(5);
    n_cmp++;
    if (vld8_rises - r0 != 3 || q8.size() != 0) begin
      n_bad++;
      $display("FAIL back_to_back: got %0d rises, %0d pending, need 3 and 0", vld8_rises - r0, q8.size());
    end
  endtask

  task automatic test_rst_midframe;
    if8.i_ready = 1'b0;
    q8.push_back(mk(9'h05A, 1'b0, 1'b0));
    send_frame(1'b0, 9'h05A, 8, 0, 1'b0, 1, -1);
    cycles(3);
    n_cmp++;
    if (if8.o_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_pre_hold: got v=%b, need 1", if8.o_valid);
    end
    rx8 = 1'b0;
    cycles(35);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({if8.o_data, if8.o_valid, if8.o_parity_err, if8.o_frame_err, if8.o_overrun, busy8} !== 14'h0) begin
      n_bad++;
      $display("FAIL rst_midframe: got d=%h v=%b busy=%b, need all zero", if8.o_data, if8.o_valid, busy8);
    end
    q8.delete();
    rx8 = 1'b1;
    if8.i_ready = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(40);
    n_cmp++;
    if (if8.o_valid !== 1'b0 || busy8 !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_recover: got v=%b busy=%b, need 0 0", if8.o_valid, busy8);
    end
  endtask

  initial begin
    test_reset();
    test_8n1_basic();
    test_parity_7e2();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_spike();
    test_back_to_back();
    test_rst_midframe();
    n_cmp++;
    if (q8.size() != 0 || q7.size() != 0) begin
      n_bad++;
      $display("FAIL final_drain: got %0d/%0d pending, need 0/0", q8.size(), q7.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver, successor to the fixed 8N1 receiver. Adds configurable data width, parity, stop-bit count, 3-sample majority voting, parity/framing/overrun detection, asynchronous reset and a valid/ready output handshake with a one-entry holding register. Sits between the board RX pin and the command decoder on the FPGA host link.

## Interface
- CLK_DIV, 10: i_clk cycles per bit; legal ≥ 4.
- DATA_BITS, 8: data bits per frame, 5..9, LSB first.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.
- SYNC_STAGES, 2: input synchroniser depth, ≥ 2.

- i_clk  in  1  sole clock
- i_rst  in  1  reset, asynchronous, active-high
- i_rx  in  1  serial line, idle high, asynchronous
- o_data  out  DATA_BITS  received word, held while o_valid
- o_valid  out  1  word available
- i_ready  in  1  consumer accepts; transfer when o_valid & i_ready
- o_parity_err  out  1  parity mismatch for held word; 0 when PARITY=0
- o_frame_err  out  1  any stop bit sampled low for held word
- o_overrun  out  1  one-cycle pulse: completed frame dropped
- o_busy  out  1  FSM not in IDLE

## Operation
- Synchroniser of SYNC_STAGES flops, all reset to 1; FSM uses last stage (rx_s).
- Bit counter cnt, 0..CLK_DIV-1; MID = CLK_DIV/2 (integer). Votes taken at cnt = MID-1, MID, MID+1; bit value = majority, decided at MID+1.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: rx_s = 0 → START, cnt = 0 in that cycle's window.
- START: vote = 1 → IDLE (glitch, nothing output). Vote = 0 → DATA.
- DATA: DATA_BITS windows; shift vote into bit index 0 first. Then PARITY if PARITY≠0, else STOP.
- PARITY: parity_err = (XOR of data ^ vote) ≠ (PARITY==1 ? 1 : 0).
- STOP: STOP_BITS windows; frame_err set if any vote = 0. At the decision cycle of the last stop window: load output and go to IDLE (frame_err = 0) or WAIT_HIGH (frame_err = 1).
- WAIT_HIGH: stay until rx_s = 1, then IDLE (break condition never re-triggers).
- Window: each window is exactly CLK_DIV cycles from the previous window start; sampling never drifts.
- Output load: if o_valid = 0 or i_ready = 1 in the load cycle, register data/flags, o_valid = 1 next cycle. Otherwise keep the old word, drop the new one, pulse o_overrun for one cycle.
- o_valid clears the cycle after o_valid & i_ready unless a load occurs in that same cycle (load wins, o_valid stays 1).

## Timing
- Reset values: o_data 0, o_valid 0, o_parity_err 0, o_frame_err 0, o_overrun 0, o_busy 0; state IDLE, cnt 0.
- i_rst mid-frame: immediate abort, partial frame discarded, held word lost.
- Line-to-detect latency: SYNC_STAGES+1 cycles after i_rx falls.
- o_valid rises 1 cycle after the last stop-bit decision, i.e. (1+DATA_BITS+(PARITY≠0)+STOP_BITS-1)·CLK_DIV + MID+2 cycles after START entry.
- o_overrun coincides with o_valid's would-be rise cycle.
- Back-to-back frames: a start edge one cycle after return to IDLE is accepted; minimum frame gap 0 bit times.

## Structure
- Package uart_pkg: parity_t enum (NONE, ODD, EVEN), rx_state_t enum, constants for the legal parameter ranges. Shared with the future uart_tx_cfg.
- Sub-module uart_bit_sampler: synchroniser, cnt, 3-sample majority, emits bit_strobe and bit_value; FSM consumes the strobes.
- Elaboration-time assertions reject out-of-range parameters.

## Test plan
- 8N1, CLK_DIV=10: send 0xA5, i_ready=1 → o_data=0xA5, o_valid high for 1 cycle, no error flags.
- 7E2: send 0x41 with wrong parity bit → o_data=0x41, o_parity_err=1, o_frame_err=0.
- 8N1: 3-cycle low glitch on idle line → FSM returns to IDLE, o_valid never asserted.
- 8N1: 0x00 with stop bit 0 held low for 30 cycles → o_frame_err=1, FSM in WAIT_HIGH until line high, no second frame.
- i_ready=0: send 0x11 then 0x22 → o_data stays 0x11, o_overrun pulses once at 0x22 completion; raise i_ready → 0x11 consumed.
- Single-cycle 0→1 spike at a bit's MID sample → majority recovers the correct data; i_rst asserted mid-DATA → all outputs at reset values next edge.
